vga_map_reader: RTL and testbench

- Read-side master for the 40x30 tile map RAM. The game-logic writer owns the write port; this block owns the read port.
- Generates 640x480@60 raster timing from the pixel clock.
- Fetches one 4-bit tile id per 16x16 tile from the map RAM.
- Delivers each tile id pixel-aligned with sync, data-enable and in-tile pixel coordinates to the downstream glyph/colour renderer.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_timing_gen.sv | 58 +++++
 rtl/vga_map_reader.sv | 85 ++++++++
 tb/tb_vga_map_reader.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster timing, tile map geometry and pipeline types
package vga_pkg;
    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HS_START   = H_ACTIVE + H_FP;
    localparam int HS_END     = HS_START + H_SYNC - 1;

    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VS_START   = V_ACTIVE + V_FP;
    localparam int VS_END     = VS_START + V_SYNC - 1;

    localparam int TILE_SHIFT = 4;
    localparam int MAP_W      = 40;
    localparam int MAP_H      = 30;
    localparam int MAP_DEPTH  = MAP_W * MAP_H;
    localparam int TILE_ID_W  = 4;
    localparam int MAP_AW     = 12;

    typedef logic [TILE_ID_W-1:0] tile_id_t;
    typedef logic [MAP_AW-1:0]    map_addr_t;

    typedef struct packed {
        logic       de;
        logic       hs_n;
        logic       vs_n;
        logic       fs;
        logic [3:0] px;
        logic [3:0] py;
    } side_t;

    localparam side_t SIDE_RESET = '{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0,
                                     px: 4'd0, py: 4'd0};

    // row*40 + col as two shifts and an add; rows are 40 tiles wide
    function automatic map_addr_t tile_addr(input logic [5:0] row, input logic [5:0] col);
        map_addr_t r;
        r = {6'd0, row};
        return (r << 5) + (r << 3) + {6'd0, col};
    endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters and sync/visible/frame-start decode
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       vis_o,
    output logic       hs_n_o,
    output logic       vs_n_o,
    output logic       fs_o
);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;
    assign vis_o   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_n_o  = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    assign vs_n_o  = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    assign fs_o    = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
endmodule

// File: rtl/vga_map_reader.sv
// rtl/vga_map_reader.sv - tile map fetch and 3-cycle pixel-aligned output pipeline
module vga_map_reader #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        map_ren,
    output logic [11:0] map_raddr,
    input  logic [3:0]  map_rdata,
    output logic [3:0]  tile_id,
    output logic [3:0]  tile_px,
    output logic [3:0]  tile_py,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    import vga_pkg::*;

    logic [9:0] h_cnt, v_cnt;
    logic       vis, hs_n, vs_n, fs;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .h_cnt_o(h_cnt),
        .v_cnt_o(v_cnt),
        .vis_o  (vis),
        .hs_n_o (hs_n),
        .vs_n_o (vs_n),
        .fs_o   (fs)
    );

    side_t     s0, s1_q, s2_q, s3_q;
    logic      map_ren_q, map_ren_d;
    map_addr_t map_raddr_q, map_raddr_d;
    tile_id_t  tile_id_q, tile_id_d;

    always_comb begin
        s0 = '{de: vis, hs_n: hs_n, vs_n: vs_n, fs: fs,
               px: h_cnt[TILE_SHIFT-1:0], py: v_cnt[TILE_SHIFT-1:0]};
        map_ren_d   = vis && (h_cnt[TILE_SHIFT-1:0] == 4'd0);
        map_raddr_d = map_ren_d ? tile_addr(v_cnt[9:4], h_cnt[9:4]) : map_raddr_q;
        // RAM data lands in S2 and holds for the whole 16-pixel span
        tile_id_d   = s2_q.de ? map_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            map_ren_q   <= 1'b0;
            map_raddr_q <= '0;
            tile_id_q   <= '0;
            s1_q        <= SIDE_RESET;
            s2_q        <= SIDE_RESET;
            s3_q        <= SIDE_RESET;
        end else begin
            map_ren_q   <= map_ren_d;
            map_raddr_q <= map_raddr_d;
            tile_id_q   <= tile_id_d;
            s1_q        <= s0;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
        end
    end

    assign map_ren     = map_ren_q;
    assign map_raddr   = map_raddr_q;
    assign tile_id     = tile_id_q;
    assign tile_px     = s3_q.px;
    assign tile_py     = s3_q.py;
    assign de          = s3_q.de;
    assign hsync       = s3_q.hs_n;
    assign vsync       = s3_q.vs_n;
    assign frame_start = s3_q.fs;
endmodule

// File: tb/tb_vga_map_reader.sv
// tb/tb_vga_map_reader.sv - scoreboard bench for vga_map_reader on a short-frame raster
module tb_vga_map_reader;
    localparam int HT    = 800;
    localparam int VA    = 32;
    localparam int VFP   = 2;
    localparam int VSY   = 2;
    localparam int VBP   = 1;
    localparam int VT    = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        map_ren;
    logic [11:0] map_raddr;
    logic [3:0]  map_rdata, ram_q, tile_id, tile_px, tile_py;
    logic        de, hsync, vsync, frame_start;
    logic        force_f = 1'b0;
    logic [3:0]  mem [0:1199];

    vga_map_reader #(.V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut (
        .clk(clk), .rst_n(rst_n), .map_ren(map_ren), .map_raddr(map_raddr),
        .map_rdata(map_rdata), .tile_id(tile_id), .tile_px(tile_px), .tile_py(tile_py),
        .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #20 clk = ~clk;

    always @(posedge clk) if (map_ren) ram_q <= mem[map_raddr];
    assign map_rdata = force_f ? 4'hF : ram_q;

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input logic [3:0] id, input logic [3:0] px,
                                       input logic [3:0] py, input logic d, input logic h,
                                       input logic v, input logic f);
        return {id, px, py, d, h, v, f};
    endfunction

    typedef struct {int h; int v; int fr; logic [15:0] vec;} exp_t;
    exp_t sbq[$];

    int mh = 0, mv = 0, mframe = 0;
    logic [3:0] cur_tile = 4'd0;
    logic exp_ren = 1'b0;
    int exp_addr = 0, ph = 0, pv = 0;
    int cyc = 0, hs_low = 0, vs_low = 0, de_cnt = 0, ren_cnt = 0, windows = 0;
    logic stats_on = 1'b0;

    task automatic step();
        exp_t e;
        logic d;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_out", pk(tile_id, tile_px, tile_py, de, hsync, vsync, frame_start),
                pk(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0));
            chk("rst_ren", {map_ren, map_raddr}, 13'd0);
            sbq.delete();
            mh = 0; mv = 0;
            stats_on = 1'b0;
        end else begin
            chk("ren", map_ren, exp_ren);
            if (exp_ren) chk("raddr", map_raddr, exp_addr);
            if (ph == 624 && pv == VA - 1) chk("raddr_last", map_raddr, 79);
            if (ph == 0 && pv == 0) chk("raddr_first", {map_ren, map_raddr}, 13'h1000);
            mh++;
            if (mh == HT) begin
                mh = 0; mv++;
                if (mv == VT) begin mv = 0; mframe++; end
            end
        end
        if (mh == 300 && mv == 20 && mframe == 0) mem[41] = 4'h6;
        force_f = (mh >= 642) || (mh < 2);
        d = (mh < 640) && (mv < VA);
        if (d && mh % 16 == 0) cur_tile = mem[(mv / 16) * 40 + mh / 16];
        e.h = mh; e.v = mv; e.fr = mframe;
        e.vec = pk(d ? cur_tile : 4'd0, 4'(mh % 16), 4'(mv % 16), d,
                   !(mh >= 656 && mh <= 751), !(mv >= VA + VFP && mv <= VA + VFP + VSY - 1),
                   mh == 0 && mv == 0);
        sbq.push_back(e);
        exp_ren = d && (mh % 16 == 0);
        exp_addr = (mv / 16) * 40 + mh / 16;
        ph = mh; pv = mv;
        if (rst_n && sbq.size() > 3) begin
            e = sbq.pop_front();
            chk("pixel", pk(tile_id, tile_px, tile_py, de, hsync, vsync, frame_start), e.vec);
            if (e.h == 37 && e.v == 5) chk("tile_37_5", {tile_id, tile_px, tile_py}, 12'h255);
            if (e.h == 37 && e.v == 21) chk("tile_37_21", {tile_id, tile_px, tile_py}, 12'hA55);
            if (e.h == 20 && e.v == 20 && e.fr == 0) chk("wr_before", tile_id, 4'h9);
            if (e.h == 20 && e.v == 21 && e.fr == 0) chk("wr_after", tile_id, 4'h6);
            if (e.h == 700 && e.v == 3) chk("blank_forced", {tile_id, de}, 5'd0);
            if (frame_start) begin
                if (stats_on) begin
                    chk("frame_period", cyc, FRAME);
                    chk("hsync_low", hs_low, 96 * VT);
                    chk("vsync_low", vs_low, VSY * HT);
                    chk("de_count", de_cnt, 640 * VA);
                    chk("ren_count", ren_cnt, 40 * VA);
                    windows++;
                end
                stats_on = 1'b1;
                cyc = 0; hs_low = 0; vs_low = 0; de_cnt = 0; ren_cnt = 0;
            end
            cyc++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (de) de_cnt++;
            if (map_ren) ren_cnt++;
        end
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 1200; i++) mem[i] = 4'(i);
        rst_n = 1'b0;
        repeat (4) step();
        rst_n = 1'b1;
        budget = 0;
        while (!(mframe == 1 && mv == 20 && mh == 100) && budget < 50000) begin
            step();
            budget++;
        end
        chk("reach_midframe", budget < 50000, 1'b1);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("fs_after_rst", frame_start, k == 3);
        end
        budget = 0;
        while (windows < 2 && budget < FRAME + 100) begin
            step();
            budget++;
        end
        chk("frames_seen", windows, 2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
